// File: rtl/univ_shift_reg_if.sv
// Control/data bundle for the universal shift register: the driver side
// supplies mode and serial/parallel inputs, and the register side returns its state.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic [CW-1:0]    count;
    logic             done;

    modport master (
        output en, mode, d, sin_r, sin_l,
        input  q, sout_l, sout_r, count, done
    );

    modport slave (
        input  en, mode, d, sin_r, sin_l,
        output q, sout_l, sout_r, count, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register (hold/load/shift/rotate/clear) with a
// saturating shift counter and a registered done flag.
module univ_shift_reg #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic              clk,
    input logic              reset,
    univ_shift_reg_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_CLR  = 3'b110,
        MODE_RSVD = 3'b111
    } mode_e;

    mode_e            mode;
    logic [WIDTH-1:0] q_r, q_next;
    logic [CW-1:0]    cnt_r, cnt_next;
    logic             done_r;
    logic             shifting;

    assign mode = mode_e'(bus.mode);

    always_comb begin
        q_next   = q_r;
        cnt_next = cnt_r;
        shifting = 1'b0;
        unique case (mode)
            MODE_LOAD: begin
                q_next   = bus.d;
                cnt_next = '0;
            end
            MODE_SHL: begin
                q_next   = {q_r[WIDTH-2:0], bus.sin_r};
                shifting = 1'b1;
            end
            MODE_SHR: begin
                q_next   = {bus.sin_l, q_r[WIDTH-1:1]};
                shifting = 1'b1;
            end
            MODE_ROL: begin
                q_next   = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                shifting = 1'b1;
            end
            MODE_ROR: begin
                q_next   = {q_r[0], q_r[WIDTH-1:1]};
                shifting = 1'b1;
            end
            MODE_CLR: begin
                q_next   = '0;
                cnt_next = '0;
            end
            MODE_HOLD, MODE_RSVD: begin
                q_next   = q_r;
                cnt_next = cnt_r;
            end
            default: begin
                q_next   = q_r;
                cnt_next = cnt_r;
            end
        endcase
        // Counter saturates at WIDTH while the data path keeps shifting.
        if (shifting && (cnt_r != CNT_FULL)) begin
            cnt_next = cnt_r + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_r    <= RESET_VALUE;
            cnt_r  <= '0;
            done_r <= 1'b0;
        end else if (bus.en) begin
            q_r    <= q_next;
            cnt_r  <= cnt_next;
            done_r <= (cnt_next == CNT_FULL);
        end
    end

    assign bus.q      = q_r;
    assign bus.count  = cnt_r;
    assign bus.done   = done_r;
    assign bus.sout_l = q_r[WIDTH-1];
    assign bus.sout_r = q_r[0];
endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed-vector bench for univ_shift_reg (WIDTH=8, RESET_VALUE=8'hA5).
module tb_univ_shift_reg;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    univ_shift_reg_if #(.WIDTH(8)) bus ();

    univ_shift_reg #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [2:0] m, input int n);
        bus.mode = m;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic expect_state(input string tag, input logic [7:0] eq, input int ec, input logic ed);
        check({tag, ".q"},     32'(bus.q),     32'(eq));
        check({tag, ".count"}, 32'(bus.count), 32'(ec));
        check({tag, ".done"},  32'(bus.done),  32'(ed));
    endtask

    logic [7:0] sout_exp;
    logic [7:0] sin_pat;

    initial begin
        reset     = 1'b0;
        bus.en    = 1'b1;
        bus.mode  = 3'b000;
        bus.d     = 8'h00;
        bus.sin_r = 1'b0;
        bus.sin_l = 1'b0;

        step();
        expect_state("reset", 8'hA5, 0, 1'b0);

        reset = 1'b1;
        apply(3'b000, 1);
        expect_state("hold_after_reset", 8'hA5, 0, 1'b0);

        // parallel-to-serial: MSB first out of sout_l
        bus.d = 8'b1000_0001;
        apply(3'b001, 1);
        expect_state("load81", 8'h81, 0, 1'b0);
        sout_exp  = 8'b1000_0001;
        bus.sin_r = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("sout_l_seq", 32'(bus.sout_l), 32'(sout_exp[7 - i]));
            if (i == 7) expect_state("shl7", 8'h80, 7, 1'b0);
            apply(3'b010, 1);
        end
        expect_state("shl8", 8'h00, 8, 1'b1);
        apply(3'b010, 1);
        expect_state("shl9_sat", 8'h00, 8, 1'b1);

        bus.d = 8'h0F;
        apply(3'b001, 1);
        expect_state("load0F", 8'h0F, 0, 1'b0);
        apply(3'b101, 4);
        expect_state("ror4", 8'hF0, 4, 1'b0);
        apply(3'b100, 4);
        expect_state("rol4", 8'h0F, 8, 1'b1);

        // serial-to-parallel: first bit in ends up at bit 0
        bus.d = 8'h00;
        apply(3'b001, 1);
        expect_state("load00", 8'h00, 0, 1'b0);
        sin_pat = 8'b1101_0010;
        for (int i = 0; i < 8; i++) begin
            bus.sin_l = sin_pat[7 - i];
            apply(3'b011, 1);
        end
        bus.sin_l = 1'b0;
        expect_state("shr8", 8'b0100_1011, 8, 1'b1);
        check("sout_r", 32'(bus.sout_r), 32'd1);
        check("sout_l", 32'(bus.sout_l), 32'd0);

        bus.en = 1'b0;
        apply(3'b010, 3);
        expect_state("en_low", 8'h4B, 8, 1'b1);
        bus.en = 1'b1;
        apply(3'b110, 1);
        expect_state("clear", 8'h00, 0, 1'b0);

        bus.d     = 8'h3C;
        apply(3'b001, 1);
        bus.sin_r = 1'b1;
        apply(3'b010, 5);
        bus.sin_r = 1'b0;
        expect_state("shl5", 8'h9F, 5, 1'b0);

        reset = 1'b0;
        bus.d = 8'hFF;
        apply(3'b001, 1);
        expect_state("reset_wins", 8'hA5, 0, 1'b0);
        reset = 1'b1;
        apply(3'b111, 1);
        expect_state("rsvd_after_reset", 8'hA5, 0, 1'b0);

        apply(3'b100, 1);
        expect_state("rol1", 8'h4B, 1, 1'b0);
        apply(3'b111, 2);
        expect_state("rsvd_hold", 8'h4B, 1, 1'b0);
        apply(3'b000, 1);
        expect_state("hold", 8'h4B, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
